pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

Consumes the PLL `LOCK` indication in the PLL output clock domain and generates a lock-qualified reset for the LCD/LED pipeline. Reset release requires lock to be stable for a programmable number of cycles. Loss of lock re-asserts reset immediately, emits an event pulse and counts the loss. Sits directly downstream of the rPLL instance; every block clocked by `clkout` takes its reset from here.

## Interface
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles required before reset release; ≥2.
- `HOLDOFF_CYCLES`, 16: minimum cycles reset stays asserted after a lock loss; ≥1.
- `SYNC_STAGES`, 2: flops in the `lock_i` synchronizer; ≥2.
- `CNT_W`, 16: width of the loss counter.
- `clk`  in  1  PLL output clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lock_i`  in  1  raw PLL lock; asynchronous to `clk`.
- `clr_i`  in  1  synchronous clear of `loss_cnt_o`.
- `rst_out_o`  out  1  active-high qualified reset to downstream logic.
- `ready_o`  out  1  high only in RUN.
- `loss_pulse_o`  out  1  one-cycle pulse per lock loss detected in RUN.
- `loss_cnt_o`  out  CNT_W  saturating count of lock losses.

## Operation
- `lock_s` is `lock_i` after `SYNC_STAGES` flops; the FSM sees only `lock_s`.
- State IDLE:
  - `lock_s=1` → QUALIFY with `qcnt=0`.
  - Otherwise stays in IDLE.
- State QUALIFY:
  - `lock_s=0` → IDLE, `qcnt` cleared.
  - `lock_s=1` and `qcnt==STABLE_CYCLES-1` → RUN.
  - Otherwise `qcnt++`.
  - QUALIFY therefore lasts exactly `STABLE_CYCLES` cycles.
- State RUN:
  - `lock_s=0` → HOLDOFF with `hcnt=0`, `loss_pulse_o=1` for one cycle, `loss_cnt_o` increments.
- State HOLDOFF:
  - `hcnt` increments every cycle, regardless of `lock_s`.
  - At `hcnt==HOLDOFF_CYCLES-1` → IDLE.
- All outputs are registered.
  - `rst_out_o=0` and `ready_o=1` only in RUN; otherwise `rst_out_o=1`, `ready_o=0`.
- Loss counter:
  - Saturates at `2^CNT_W-1`.
  - `clr_i` alone sets it to 0.
  - `clr_i` in the same cycle as a loss sets it to 1, so the loss is not dropped.
- Lock glitches shorter than one `clk` period may be missed. This is acceptable.
- Lock toggling during QUALIFY restarts qualification and does not count as a loss.

## Timing
- Reset values: state IDLE, `qcnt=hcnt=0`, synchronizer flops 0, `rst_out_o=1`, `ready_o=0`, `loss_pulse_o=0`, `loss_cnt_o=0`.
- Release latency: `lock_i` rise first captured at edge k; `rst_out_o` falls at edge k+`SYNC_STAGES`+`STABLE_CYCLES`.
- Loss latency: `lock_i` fall first captured at edge k; `rst_out_o` rises and `loss_pulse_o` asserts at edge k+`SYNC_STAGES`. The pulse deasserts on the next edge.
- Minimum reset width after a loss is `HOLDOFF_CYCLES` cycles in HOLDOFF, plus the full QUALIFY time.
- Asserting `rst` mid-operation forces all reset values immediately and clears `loss_cnt_o`. Deassertion restarts from IDLE.

## Configuration
- `PLL_LOCK_MON_LOSS_CNT_EN` defined: the loss counter and the `clr_i` logic are built as described.
- Macro undefined: no counter register is built and `loss_cnt_o` is tied to 0. `clr_i` is ignored. `loss_pulse_o` and all FSM behaviour are unchanged.

## Structure
- Package `pll_lock_mon_pkg`:
  - FSM state enum (IDLE, QUALIFY, RUN, HOLDOFF).
  - Default parameter constants.
- Sub-module `sync_ff`: parameterized `SYNC_STAGES` single-bit synchronizer with async active-high reset to 0.
  - Instantiated once for `lock_i`.
  - Carries the codebase's async-register attribute.
- Top holds the FSM, `qcnt`/`hcnt` (each sized by `$clog2`) and the optional loss counter.

## Test plan
- **Reset release:** `STABLE_CYCLES=8`, `SYNC_STAGES=2`. `lock_i` rises and is captured at edge 0 → `rst_out_o` falls and `ready_o` rises at edge 10, not earlier.
- **Qualification abort:** `lock_i` high 5 cycles, low 3, then high → no release at edge 10. Release occurs 10 edges after the second rise. `loss_pulse_o` and `loss_cnt_o` stay 0.
- **Lock loss in RUN:** `HOLDOFF_CYCLES=4`. Drop `lock_i` at edge k →
  - `rst_out_o=1` and a single-cycle `loss_pulse_o` at edge k+2.
  - `loss_cnt_o=1`.
  - Re-raising `lock_i` immediately still gives the release no earlier than 4+8 cycles after entering HOLDOFF.
- **Saturation and clear:** `CNT_W=2`. Five losses → `loss_cnt_o=3`. `clr_i` alone → 0. `clr_i` coincident with a loss pulse → 1.
- **Async reset mid-QUALIFY and mid-RUN:** all outputs take reset values without waiting for a clock edge. `loss_cnt_o=0`, and a full requalification is required.
- **Macro off:** repeat the lock-loss test → `loss_cnt_o` stays 0. Pulse and reset timing are identical to the macro-on run.

Source files
------------

// File: rtl/pll_lock_mon_pkg.sv
// Shared types and default constants for the PLL lock monitor.
package pll_lock_mon_pkg;

  // Lock-qualification FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_RUN     = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 16;
  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_CNT_W          = 16;

endpackage

// File: rtl/pll_lock_monitor_sync_ff.sv
// sync_ff: multi-flop single-bit synchronizer, async active-high reset to 0.
// The flops carry the async-register attribute so placement keeps them
// adjacent and timing treats the first stage as a metastability catcher.
module sync_ff
  import pll_lock_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: turns the raw PLL lock into a lock-qualified reset for
// everything clocked by the PLL output. Reset is released only after lock
// has been stable for STABLE_CYCLES; a lock loss in RUN re-asserts reset at
// once, pulses loss_pulse_o and (optionally) counts the loss.
// Optional feature macro: PLL_LOCK_MON_LOSS_CNT_EN builds the saturating
// loss counter and its clr_i clear; without it loss_cnt_o is tied to 0.
module pll_lock_monitor
  import pll_lock_mon_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock_i,
  input  logic             clr_i,
  output logic             rst_out_o,
  output logic             ready_o,
  output logic             loss_pulse_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  // Counter widths; a 1-cycle holdoff still needs a 1-bit counter.
  localparam int unsigned QW = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
  localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYCLES - 1);

  logic          lock_s;
  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          loss;
  logic          rst_out_q, ready_q, pulse_q;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock_i),
    .q   (lock_s)
  );

  // State and qualification/holdoff counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      qcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state logic; loss marks the RUN->HOLDOFF transition.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    hcnt_d  = hcnt_q;
    loss    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        qcnt_d = '0;
        hcnt_d = '0;
        if (lock_s) state_d = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!lock_s) begin
          state_d = ST_IDLE;
          qcnt_d  = '0;
        end else if (qcnt_q == Q_LAST) begin
          state_d = ST_RUN;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_HOLDOFF;
          hcnt_d  = '0;
          loss    = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // Holdoff runs to completion whatever lock_s does.
        if (hcnt_q == H_LAST) begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        qcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they change on the
  // same edge as the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      rst_out_q <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      pulse_q   <= loss;
    end
  end

  assign rst_out_o    = rst_out_q;
  assign ready_o      = ready_q;
  assign loss_pulse_o = pulse_q;

`ifdef PLL_LOCK_MON_LOSS_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q;

  // Saturating loss counter; a clear coinciding with a loss keeps that loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= loss ? CNT_W'(1) : '0;
    end else if (loss && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign loss_cnt_o = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed table, hand-written corner sequences
// and random lock waveforms against a behavioural model.
module tb_pll_lock_monitor;

  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int SYNC   = 2;
  localparam int CW     = 2;
  localparam int CMAX   = (1 << CW) - 1;
`ifdef PLL_LOCK_MON_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          lock_i;
  logic          clr_i;
  logic          rst_out_o;
  logic          ready_o;
  logic          loss_pulse_o;
  logic [CW-1:0] loss_cnt_o;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .STABLE_CYCLES (STABLE),
    .HOLDOFF_CYCLES(HOLD),
    .SYNC_STAGES   (SYNC),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lock_i      (lock_i),
    .clr_i       (clr_i),
    .rst_out_o   (rst_out_o),
    .ready_o     (ready_o),
    .loss_pulse_o(loss_pulse_o),
    .loss_cnt_o  (loss_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Rules: lock is seen SYNC edges late. Outside RUN and holdoff, the reset
  // is released once the seen lock has been high on STABLE+1 consecutive
  // edges. A low seen lock in RUN is a loss; afterwards HOLD edges are
  // ignored completely before counting may begin again.
  bit m_sync[SYNC];
  bit m_running;
  bit m_pulse;
  int m_hold;
  int m_streak;
  int m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_running = 1'b0;
    m_pulse   = 1'b0;
    m_hold    = 0;
    m_streak  = 0;
    m_cnt     = 0;
  endfunction

  function automatic void model_step(input bit l, input bit c);
    bit ls;
    bit lost;
    ls = m_sync[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = l;
    lost = 1'b0;
    if (m_running) begin
      if (!ls) begin
        m_running = 1'b0;
        m_hold    = HOLD;
        lost      = 1'b1;
      end
      m_streak = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      m_streak = 0;
    end else if (ls) begin
      m_streak++;
      if (m_streak == STABLE + 1) begin
        m_running = 1'b1;
        m_streak  = 0;
      end
    end else begin
      m_streak = 0;
    end
    m_pulse = lost;
    if (CNT_EN) begin
      if (c) m_cnt = lost ? 1 : 0;
      else if (lost && m_cnt < CMAX) m_cnt++;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: drive inputs at the falling edge, let the model take the
  // rising edge, compare on the next falling edge.
  task automatic step(input bit l, input bit c, input string tag);
    lock_i = l;
    clr_i  = c;
    @(posedge clk);
    model_step(l, c);
    @(negedge clk);
    check({tag, " rst_out_o"},    int'(rst_out_o),    int'(!m_running));
    check({tag, " ready_o"},      int'(ready_o),      int'(m_running));
    check({tag, " loss_pulse_o"}, int'(loss_pulse_o), int'(m_pulse));
    check({tag, " loss_cnt_o"},   int'(loss_cnt_o),   m_cnt);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    lock_i = 1'b0;
    clr_i  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  // Reset asserted between edges: outputs must change with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, " async rst_out_o"}, int'(rst_out_o),    1);
    check({tag, " async ready_o"},   int'(ready_o),      0);
    check({tag, " async pulse"},     int'(loss_pulse_o), 0);
    check({tag, " async cnt"},       int'(loss_cnt_o),   0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Hold lock high until ready, bounded.
  task automatic wait_ready(input int budget, input string tag);
    int n;
    n = 0;
    while (!ready_o && n < budget) begin
      step(1'b1, 1'b0, tag);
      n++;
    end
    check({tag, " wait_ready reached"}, int'(ready_o), 1);
  endtask

  // Drop lock from RUN; clr_i optionally coincides with the loss edge.
  task automatic lose(input bit clr_at_loss, input string tag);
    step(1'b0, 1'b0, tag);
    step(1'b0, 1'b0, tag);
    step(1'b0, clr_at_loss, tag);
    check({tag, " loss pulse at k+2"}, int'(loss_pulse_o), 1);
    check({tag, " rst at k+2"},        int'(rst_out_o),    1);
    step(1'b0, 1'b0, tag);
    check({tag, " pulse one cycle"},   int'(loss_pulse_o), 0);
  endtask

  // Requalify from a clean reset: release exactly STABLE+SYNC edges later.
  task automatic requalify(input string tag);
    for (int i = 0; i < STABLE + SYNC + 1; i++) begin
      step(1'b1, 1'b0, tag);
      check($sformatf("%s requal[%0d] rst", tag, i), int'(rst_out_o),
            (i < STABLE + SYNC) ? 1 : 0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit lock;
    bit clr;
    bit rst;
    bit rdy;
    bit pulse;
    int cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t tv[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int run_len;
    bit lvl;

    // Release at edge 10, loss captured at edge 12 seen at edge 14,
    // immediate relock: holdoff to edge 18, requalified at edge 27.
    for (int n = 0; n < NV; n++) begin
      tv[n].lock  = (n < 12) || (n >= 16);
      tv[n].clr   = 1'b0;
      tv[n].rst   = !((n >= 10 && n < 14) || n >= 27);
      tv[n].rdy   = !tv[n].rst;
      tv[n].pulse = (n == 14);
      tv[n].cnt   = (CNT_EN && n >= 14) ? 1 : 0;
    end

    rst    = 1'b1;
    lock_i = 1'b0;
    clr_i  = 1'b0;
    model_reset();
    #1;
    check("reset rst_out_o", int'(rst_out_o),    1);
    check("reset ready_o",   int'(ready_o),      0);
    check("reset pulse",     int'(loss_pulse_o), 0);
    check("reset cnt",       int'(loss_cnt_o),   0);
    do_reset();

    // Release, loss and immediate relock from the table.
    for (int i = 0; i < NV; i++) begin
      step(tv[i].lock, tv[i].clr, "tbl");
      check($sformatf("tbl[%0d] rst_out_o", i), int'(rst_out_o),    int'(tv[i].rst));
      check($sformatf("tbl[%0d] ready_o", i),   int'(ready_o),      int'(tv[i].rdy));
      check($sformatf("tbl[%0d] pulse", i),     int'(loss_pulse_o), int'(tv[i].pulse));
      check($sformatf("tbl[%0d] cnt", i),       int'(loss_cnt_o),   tv[i].cnt);
    end

    // Qualification abort: 5 high, 3 low, then high; release at edge 18.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      lvl = (i < 5) || (i >= 8);
      step(lvl, 1'b0, "abort");
      check($sformatf("abort[%0d] rst", i),   int'(rst_out_o),    (i < 18) ? 1 : 0);
      check($sformatf("abort[%0d] pulse", i), int'(loss_pulse_o), 0);
      check($sformatf("abort[%0d] cnt", i),   int'(loss_cnt_o),   0);
    end

    // Saturation and clear.
    for (int i = 0; i < 5; i++) begin
      lose(1'b0, "sat");
      wait_ready(40, "sat");
    end
    check("sat count after 5 losses", int'(loss_cnt_o), CNT_EN ? CMAX : 0);
    lose(1'b1, "clr_loss");
    check("clr with loss", int'(loss_cnt_o), CNT_EN ? 1 : 0);
    wait_ready(40, "clr_loss");
    step(1'b1, 1'b1, "clr_alone");
    check("clr alone", int'(loss_cnt_o), 0);

    // Async reset mid-QUALIFY, then mid-RUN.
    lose(1'b0, "pre_q");
    for (int i = 0; i < HOLD + 4; i++) step(1'b0, 1'b0, "pre_q");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "mid_q");
    async_reset("mid_q");
    requalify("mid_q");
    lose(1'b0, "pre_r");
    wait_ready(40, "pre_r");
    async_reset("mid_r");
    requalify("mid_r");

    // Random lock waveform with occasional clears.
    do_reset();
    lvl = 1'b0;
    for (int i = 0; i < 80; i++) begin
      lvl     = ~lvl;
      run_len = lvl ? $urandom_range(1, 24) : $urandom_range(1, 8);
      for (int j = 0; j < run_len; j++) begin
        step(lvl, ($urandom_range(0, 15) == 0), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
